// File: rtl/gpo_pad_serializer.sv
// gpo_pad_serializer: MSB-first serial pad driver with lead/trail marks.
// Optional pad loopback check built when GPO_LOOPBACK_CHECK_EN is defined.
module gpo_pad_serializer #(
  parameter int DW   = 8,
  parameter int DIVW = 8
) (
  input  logic            CLK_I,
  input  logic            RST_I,
  input  logic [DW-1:0]   DATA_I,
  input  logic            VALID_I,
  output logic            READY_O,
  input  logic [DIVW-1:0] DIV_I,
  input  logic [1:0]      DS_I,
  output logic            DO_O,
  output logic            OE_O,
  output logic [1:0]      DS_O,
  output logic            BUSY_O,
  input  logic            PAD_DI_I,
  input  logic            ERR_CLR_I,
  output logic            ERR_O
);

  localparam int BW = (DW > 1) ? $clog2(DW) : 1;
  localparam logic [BW-1:0] LAST = BW'(DW - 1);

  typedef enum logic [1:0] {
    IDLE,
    LEAD,
    SHIFT,
    TRAIL
  } state_t;

  state_t          state_q;
  logic [DIVW-1:0] cnt_q;
  logic [DIVW-1:0] div_q;
  logic [BW-1:0]   bit_q;
  logic [DW-1:0]   sh_q;
  logic [1:0]      ds_q;
  logic            do_q;
  logic            oe_q;
  logic            rdy_en_q;
  logic            per_end;
  logic            accept;

  assign per_end = (cnt_q == div_q);

  // rdy_en_q keeps READY_O low for the first clock out of reset
  assign READY_O = rdy_en_q &
                   ((state_q == IDLE) |
                    ((state_q == TRAIL) & per_end));
  assign accept  = VALID_I & READY_O;

  assign DO_O   = do_q;
  assign OE_O   = oe_q;
  assign DS_O   = ds_q;
  assign BUSY_O = (state_q != IDLE);

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      div_q    <= '0;
      bit_q    <= '0;
      sh_q     <= '0;
      ds_q     <= 2'b01;
      do_q     <= 1'b1;
      oe_q     <= 1'b0;
      rdy_en_q <= 1'b0;
    end else begin
      rdy_en_q <= 1'b1;
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            state_q <= LEAD;
            cnt_q   <= '0;
            sh_q    <= DATA_I;
            div_q   <= DIV_I;
            ds_q    <= DS_I;
            oe_q    <= 1'b1;
            do_q    <= 1'b1;
          end
        end
        LEAD: begin
          if (per_end) begin
            state_q <= SHIFT;
            cnt_q   <= '0;
            bit_q   <= '0;
            do_q    <= sh_q[DW-1];
            sh_q    <= sh_q << 1;
          end else begin
            cnt_q <= cnt_q + DIVW'(1);
          end
        end
        SHIFT: begin
          if (per_end) begin
            cnt_q <= '0;
            if (bit_q == LAST) begin
              state_q <= TRAIL;
              do_q    <= 1'b1;
            end else begin
              bit_q <= bit_q + BW'(1);
              do_q  <= sh_q[DW-1];
              sh_q  <= sh_q << 1;
            end
          end else begin
            cnt_q <= cnt_q + DIVW'(1);
          end
        end
        TRAIL: begin
          if (per_end) begin
            cnt_q <= '0;
            if (accept) begin
              // back-to-back word: skip LEAD, keep OE high
              state_q <= SHIFT;
              bit_q   <= '0;
              div_q   <= DIV_I;
              ds_q    <= DS_I;
              do_q    <= DATA_I[DW-1];
              sh_q    <= DATA_I << 1;
            end else begin
              state_q <= IDLE;
              oe_q    <= 1'b0;
              do_q    <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + DIVW'(1);
          end
        end
      endcase
    end
  end

`ifdef GPO_LOOPBACK_CHECK_EN
  logic err_q;
  logic err_d;
  logic miss;

  // compare only once the pad has had a full clock to settle
  assign miss = (state_q == SHIFT) & per_end &
                (div_q != '0) & (PAD_DI_I != do_q);

  always_comb begin
    err_d = err_q;
    if (ERR_CLR_I) err_d = 1'b0;
    if (miss) err_d = 1'b1;
  end

  always_ff @(posedge CLK_I) begin
    if (RST_I) err_q <= 1'b0;
    else err_q <= err_d;
  end

  assign ERR_O = err_q;
`else
  logic unused_loopback;
  assign unused_loopback = PAD_DI_I ^ ERR_CLR_I;
  assign ERR_O = 1'b0;
`endif

endmodule

// File: tb/tb_gpo_pad_serializer.sv
// tb_gpo_pad_serializer: directed vectors and frame sequences for
// gpo_pad_serializer (loopback cases when GPO_LOOPBACK_CHECK_EN is set).
module tb_gpo_pad_serializer;

  localparam int DW   = 8;
  localparam int DIVW = 8;

  logic            CLK_I;
  logic            RST_I;
  logic [DW-1:0]   DATA_I;
  logic            VALID_I;
  logic            READY_O;
  logic [DIVW-1:0] DIV_I;
  logic [1:0]      DS_I;
  logic            DO_O;
  logic            OE_O;
  logic [1:0]      DS_O;
  logic            BUSY_O;
  logic            PAD_DI_I;
  logic            ERR_CLR_I;
  logic            ERR_O;

  logic pad_force;
  logic pad_val;

  int total;
  int passed;

  gpo_pad_serializer #(.DW(DW), .DIVW(DIVW)) dut (
    .CLK_I     (CLK_I),
    .RST_I     (RST_I),
    .DATA_I    (DATA_I),
    .VALID_I   (VALID_I),
    .READY_O   (READY_O),
    .DIV_I     (DIV_I),
    .DS_I      (DS_I),
    .DO_O      (DO_O),
    .OE_O      (OE_O),
    .DS_O      (DS_O),
    .BUSY_O    (BUSY_O),
    .PAD_DI_I  (PAD_DI_I),
    .ERR_CLR_I (ERR_CLR_I),
    .ERR_O     (ERR_O)
  );

  // pad model: receiver reads back the driven level unless forced
  assign PAD_DI_I = pad_force ? pad_val : DO_O;

  initial CLK_I = 1'b0;
  always #5 CLK_I = ~CLK_I;

  typedef struct packed {
    logic       vld;
    logic [7:0] data;
    logic [7:0] div;
    logic [1:0] ds;
    logic [5:0] exp;
  } vec_t;

  vec_t tab [11];

  task automatic step();
    @(posedge CLK_I);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic logic [5:0] obs();
    return {OE_O, DO_O, READY_O, BUSY_O, DS_O};
  endfunction

  task automatic frame(input string nm, input logic [7:0] d,
                       input logic [7:0] dv, input logic [1:0] ds,
                       input logic [1:0] ds_mid);
    int n;
    int bad;
    int p;
    int per;
    int lim;
    logic e;
    per = int'(dv) + 1;
    lim = (DW + 2) * per + 8;
    chk({nm, "_rdy"}, 32'(READY_O), 32'd1);
    VALID_I = 1'b1;
    DATA_I  = d;
    DIV_I   = dv;
    DS_I    = ds;
    step();
    VALID_I = 1'b0;
    DATA_I  = ~d;
    DIV_I   = '0;
    DS_I    = ds_mid;
    n   = 0;
    bad = 0;
    while (OE_O === 1'b1 && n < lim) begin
      p = n / per;
      if (p == 0 || p >= DW + 1) e = 1'b1;
      else e = d[DW-p];
      if (DO_O !== e || DS_O !== ds || BUSY_O !== 1'b1) bad++;
      n++;
      step();
    end
    chk({nm, "_len"}, 32'(n), 32'((DW + 2) * per));
    chk({nm, "_bits"}, 32'(bad), 32'd0);
    chk({nm, "_idle"}, 32'(obs()), 32'({1'b0, 1'b1, 1'b1, 1'b0, ds}));
  endtask

  initial begin
    int n;
    int bad;
    int acc;
    logic e;
    total     = 0;
    passed    = 0;
    pad_force = 1'b0;
    pad_val   = 1'b0;
    RST_I     = 1'b1;
    VALID_I   = 1'b0;
    DATA_I    = '0;
    DIV_I     = '0;
    DS_I      = 2'b00;
    ERR_CLR_I = 1'b0;

    tab[0]  = {1'b1, 8'hA5, 8'd0, 2'b10, 6'b110110};
    tab[1]  = {1'b0, 8'h00, 8'd0, 2'b01, 6'b110110};
    tab[2]  = {1'b0, 8'h00, 8'd0, 2'b01, 6'b100110};
    tab[3]  = {1'b1, 8'h00, 8'd0, 2'b01, 6'b110110};
    tab[4]  = {1'b0, 8'h00, 8'd0, 2'b01, 6'b100110};
    tab[5]  = {1'b0, 8'h00, 8'd0, 2'b01, 6'b100110};
    tab[6]  = {1'b0, 8'h00, 8'd0, 2'b01, 6'b110110};
    tab[7]  = {1'b0, 8'h00, 8'd0, 2'b01, 6'b100110};
    tab[8]  = {1'b0, 8'h00, 8'd0, 2'b01, 6'b110110};
    tab[9]  = {1'b0, 8'h00, 8'd0, 2'b01, 6'b111110};
    tab[10] = {1'b0, 8'h00, 8'd0, 2'b01, 6'b011010};

    // reset state and READY release
    step();
    step();
    chk("reset_obs", 32'(obs()), 32'(6'b010001));
    chk("reset_err", 32'(ERR_O), 32'd0);
    RST_I = 1'b0;
    step();
    chk("post_reset", 32'(obs()), 32'(6'b011001));

    // A5, DIV=0, cycle by cycle
    for (int i = 0; i < 11; i++) begin
      VALID_I = tab[i].vld;
      DATA_I  = tab[i].data;
      DIV_I   = tab[i].div;
      DS_I    = tab[i].ds;
      step();
      chk($sformatf("vec%0d", i), 32'(obs()), 32'(tab[i].exp));
    end
    VALID_I = 1'b0;
    step();

    frame("div3", 8'h01, 8'd3, 2'b01, 2'b01);
    frame("ds", 8'h3C, 8'd1, 2'b11, 2'b00);
    frame("div0", 8'h5A, 8'd0, 2'b10, 2'b11);
    frame("divmax", 8'h96, 8'hFF, 2'b01, 2'b10);

    // back-to-back FF then 00 with VALID held
    VALID_I = 1'b1;
    DATA_I  = 8'hFF;
    DIV_I   = 8'd1;
    DS_I    = 2'b01;
    acc = 0;
    if (READY_O === 1'b1) acc++;
    step();
    DATA_I = 8'h00;
    n   = 0;
    bad = 0;
    while (OE_O === 1'b1 && n < 100) begin
      e = (n < 20 || n >= 36);
      if (DO_O !== e) bad++;
      n++;
      if (VALID_I === 1'b1 && READY_O === 1'b1) acc++;
      step();
      if (acc >= 2) VALID_I = 1'b0;
    end
    VALID_I = 1'b0;
    chk("b2b_len", 32'(n), 32'd38);
    chk("b2b_bits", 32'(bad), 32'd0);
    chk("b2b_accepts", 32'(acc), 32'd2);
    step();

    // reset in the middle of SHIFT
    VALID_I = 1'b1;
    DATA_I  = 8'hA5;
    DIV_I   = 8'd0;
    DS_I    = 2'b11;
    step();
    VALID_I = 1'b0;
    for (int i = 0; i < 5; i++) step();
    chk("mid_shift", 32'(obs()), 32'(6'b100111));
    RST_I = 1'b1;
    step();
    chk("mid_reset", 32'(obs()), 32'(6'b010001));
    RST_I = 1'b0;
    step();
    chk("mid_release", 32'(obs()), 32'(6'b011001));
    n = 0;
    for (int i = 0; i < 4; i++) begin
      if (OE_O !== 1'b0) n++;
      step();
    end
    chk("mid_no_resume", 32'(n), 32'd0);

`ifdef GPO_LOOPBACK_CHECK_EN
    // pad stuck high: last bit of FE mismatches
    pad_force = 1'b1;
    pad_val   = 1'b1;
    VALID_I = 1'b1;
    DATA_I  = 8'hFE;
    DIV_I   = 8'd1;
    DS_I    = 2'b01;
    step();
    VALID_I = 1'b0;
    n   = 0;
    bad = 0;
    while (OE_O === 1'b1 && n < 40) begin
      e = (n >= 18);
      if (ERR_O !== e) bad++;
      n++;
      step();
    end
    chk("lb_len", 32'(n), 32'd20);
    chk("lb_err", 32'(bad), 32'd0);
    step();
    step();
    chk("lb_sticky", 32'(ERR_O), 32'd1);
    ERR_CLR_I = 1'b1;
    step();
    ERR_CLR_I = 1'b0;
    chk("lb_clear", 32'(ERR_O), 32'd0);
    // clear held through the frame: set wins on the mismatch clock
    ERR_CLR_I = 1'b1;
    VALID_I = 1'b1;
    step();
    VALID_I = 1'b0;
    n   = 0;
    bad = 0;
    while (OE_O === 1'b1 && n < 40) begin
      e = (n == 18);
      if (ERR_O !== e) bad++;
      n++;
      step();
    end
    ERR_CLR_I = 1'b0;
    chk("lb_set_wins", 32'(bad), 32'd0);
    pad_force = 1'b0;
`else
    // checker absent: ERR_O stays low whatever the pad does
    pad_force = 1'b1;
    pad_val   = 1'b0;
    VALID_I = 1'b1;
    DATA_I  = 8'hFE;
    DIV_I   = 8'd1;
    DS_I    = 2'b01;
    step();
    VALID_I = 1'b0;
    n   = 0;
    bad = 0;
    while (OE_O === 1'b1 && n < 40) begin
      if (ERR_O !== 1'b0) bad++;
      n++;
      step();
    end
    chk("noerr_len", 32'(n), 32'd20);
    chk("noerr_err", 32'(bad), 32'd0);
    pad_force = 1'b0;
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/gpo_pad_serializer.md
GPO_PAD_SERIALIZER -- requirements
Module: gpo_pad_serializer

Interface
REQ-001 Parameter DW, default 8, data word width in bits.
REQ-002 Parameter DIVW, default 8, bit-period divider width in bits.
REQ-003 CLK_I  in  1  single clock; all logic SHALL be on its rising edge.
REQ-004 RST_I  in  1  reset; synchronous, active-high.
REQ-005 DATA_I  in  DW  word to transmit.
REQ-006 VALID_I  in  1  DATA_I/DIV_I/DS_I valid.
REQ-007 READY_O  out  1  word accepted on VALID_I&READY_O at a rising edge.
REQ-008 DIV_I  in  DIVW  bit period = DIV_I+1 clocks.
REQ-009 DS_I  in  2  pad drive-strength request.
REQ-010 DO_O  out  1  data to the output pad driver.
REQ-011 OE_O  out  1  pad output enable.
REQ-012 DS_O  out  2  drive strength to the pad.
REQ-013 BUSY_O  out  1  high whenever the state is not IDLE.
REQ-014 PAD_DI_I  in  1  pad receiver readback; DI_O[0] of the input cell.
REQ-015 ERR_CLR_I  in  1  clears ERR_O.
REQ-016 ERR_O  out  1  sticky loopback mismatch flag.

Function
REQ-017 FSM states SHALL be IDLE, LEAD, SHIFT and TRAIL; each state lasts whole bit periods of DIV+1 clocks, using the latched DIV.
REQ-018 READY_O SHALL be 1 in IDLE and in the final clock of TRAIL, and 0 otherwise.
REQ-019 On acceptance, the block SHALL latch DATA_I, DIV_I and DS_I; input changes afterwards SHALL not affect the frame in progress.
REQ-020 DS_O SHALL take the latched DS_I on the clock after acceptance and hold it until the next acceptance.
REQ-021 Acceptance in IDLE SHALL enter LEAD on the next clock, with OE_O=1 and DO_O=1 for one bit period.
REQ-022 In SHIFT, DO_O SHALL present DW bits MSB first, one bit period each, with OE_O=1.
REQ-023 After the last bit, the FSM SHALL enter TRAIL: DO_O=1 and OE_O=1 for one bit period.
REQ-024 At the end of TRAIL without acceptance, the FSM SHALL go to IDLE with OE_O=0 and DO_O=1.
REQ-025 On acceptance in the final TRAIL clock, the FSM SHALL go directly to SHIFT, skip LEAD, and keep OE_O=1 without a gap.
REQ-026 Frame length from acceptance in IDLE to OE_O falling SHALL be (DW+2)*(DIV+1) clocks.
REQ-027 DIV=0 SHALL give one clock per bit; DIV=2^DIVW-1 SHALL give 2^DIVW clocks per bit, with no counter overflow.
REQ-028 VALID_I while READY_O=0 SHALL be ignored, and no word SHALL be lost or duplicated.

Reset
REQ-029 While RST_I=1 at an edge, the block SHALL force state IDLE, OE_O=0, DO_O=1, DS_O=2'b01, READY_O=0, BUSY_O=0 and ERR_O=0, and clear all counters.
REQ-030 Reset mid-frame SHALL abort the frame; OE_O SHALL be 0 on the clock after the reset edge, with no partial resumption.
REQ-031 READY_O SHALL rise on the first clock after RST_I deasserts.

Configuration
REQ-032 Macro GPO_LOOPBACK_CHECK_EN defined: in SHIFT with latched DIV>=1, the block SHALL sample PAD_DI_I in the last clock of each bit period; mismatch with DO_O SHALL set ERR_O on the next clock.
REQ-033 ERR_O SHALL stay set until ERR_CLR_I=1 or reset; a simultaneous clear and new mismatch SHALL leave ERR_O=1.
REQ-034 Macro GPO_LOOPBACK_CHECK_EN not defined: ERR_O SHALL be constant 0, PAD_DI_I and ERR_CLR_I SHALL be ignored, and the ports SHALL remain present.

Verification
REQ-035 Single frame: DATA_I=8'hA5, DIV_I=0 -> LEAD 1 clk high, DO_O sequence 1,0,1,0,0,1,0,1, TRAIL 1 clk, OE_O high for exactly 10 clocks.
REQ-036 Divider: DATA_I=8'h01, DIV_I=3 -> each bit 4 clocks, OE_O high 40 clocks; DIV_I changed mid-frame to 0 has no effect.
REQ-037 Back-to-back: VALID_I held with 8'hFF then 8'h00, DIV_I=1 -> second frame starts SHIFT directly after TRAIL, OE_O never drops, total 38 clocks high.
REQ-038 Reset mid-SHIFT at bit 4 -> OE_O=0 and DO_O=1 next clock, DS_O=2'b01, READY_O=1 the clock after RST_I falls.
REQ-039 GPO_LOOPBACK_CHECK_EN defined, DIV_I=1, PAD_DI_I stuck at 1, DATA_I=8'hFE -> ERR_O rises after bit 0 and stays set until ERR_CLR_I pulses.
REQ-040 Drive strength: DS_I=2'b11 at acceptance, then DS_I=2'b00 during the frame -> DS_O=2'b11 for the whole frame and in IDLE after it.
